uart_tx_mmio: RTL
=================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter on the CPU data bus, in parallel with data SRAM.
//  Decodes a 16-byte window, queues bytes in a FIFO, serialises 8N1 frames on txd.
//  The top level selects between this block's read data and the SRAM's using rd_hit_q.
// PARAMETERS
//  BASE_ADDR    32'hFFFF_0000  window base; [3:0] must be 0
//  FIFO_DEPTH   8              TX FIFO entries; power of 2, >=2
//  DEFAULT_DIV  16'd868        clock cycles per bit after reset
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst         in   1   asynchronous, active-low reset
//  data_read   in   1   CPU read strobe
//  data_write  in   4   CPU byte-lane write enables
//  data_addr   in   32  CPU byte address
//  data_in     in   32  CPU write data
//  rd_data     out  32  registered read data
//  rd_hit_q    out  1   registered: previous-cycle read targeted this window
//  txd         out  1   serial output, idle high
//  irq         out  1   TX-done interrupt, level
// BEHAVIOUR
//  Reset (rst=0, async): txd=1, rd_data=0, rd_hit_q=0, irq=0, FIFO empty,
//   DIV=DEFAULT_DIV, CTRL=0, OVF=0, FSM=IDLE. A frame in progress aborts; txd goes high immediately.
//  Decode: hit = (data_addr[31:4]==BASE_ADDR[31:4]). Register select is data_addr[3:2].
//  Registers:
//   +0x0 TXDATA  W: a write with data_write[0] pushes data_in[7:0]. R: 0.
//   +0x4 STATUS  R: [0]full [1]empty [2]busy [3]OVF [7:4]count, other bits 0.
//                W: data_write[0] & data_in[3] clears OVF.
//   +0x8 DIV     R/W [15:0] per byte lane; [31:16] read 0. Written values <2 are stored as 2.
//   +0xC CTRL    R/W [0]irq_en; other bits 0.
//  Read: one-cycle latency, matching the SRAM.
//   - Cycle N, data_read&hit: rd_data<=reg value, rd_hit_q<=1.
//   - Otherwise rd_data<=0, rd_hit_q<=0.
//   - Reads have no side effects.
//  Push on a full FIFO:
//   - If no pop occurs in the same cycle, the byte is dropped and OVF<=1 (sticky).
//   - If a pop occurs in the same cycle, the push is accepted and count is unchanged.
//   - Push and pop never both fire on an empty FIFO; pop requires !empty.
//  TX FSM: IDLE -> START -> DATA -> STOP, with baud counter bcnt.
//   - IDLE, FIFO non-empty: pop, load shift register, latch DIV into div_q,
//     bcnt<=div_q-1, go to START. txd=0 on the next cycle.
//   - Each bit holds for div_q cycles; bcnt counts down, and the bit advances at bcnt==0.
//   - DATA shifts LSB first, 8 bits, counted by a 3-bit index (wraps 7->0 on exit).
//   - STOP drives txd=1 for div_q cycles. At its last cycle: if FIFO non-empty, pop
//     and go directly to START (no gap); otherwise go to IDLE.
//   - busy=1 in every state except IDLE.
//   - A DIV write mid-frame affects only the next frame.
//  Latency: write TXDATA at cycle N -> FIFO non-empty N+1 -> pop N+1 -> txd falls N+2.
//   A frame is 10*div_q cycles.
//  irq = CTRL.irq_en & FIFO empty & !busy, registered (one cycle behind the condition).
// STRUCTURE
//  Package uart_pkg: register offsets (TXDATA/STATUS/DIV/CTRL), STATUS bit indices,
//   FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
//  Sub-module uart_tx_fifo: sync FIFO (DEPTH, WIDTH=8). Interface: push, pop, din,
//   dout, full, empty, count. Wrap-around pointers carry an extra MSB for full/empty.
//  Top of block: bus decode, register file, baud counter, TX FSM.
// TESTING
//  1. Reset, then read STATUS -> next-cycle rd_data=32'h0000_0002, rd_hit_q=1.
//     Read DIV -> 868. txd stays 1.
//  2. DIV=4; write 0xA5 to TXDATA -> txd over 40 cycles:
//     0 | 1,0,1,0,0,1,0,1 | 1, 4 cycles each. Start bit begins 2 cycles after the write.
//  3. DIV=2; write 10 bytes back-to-back -> first 9 accepted (1 popped + 8 queued).
//     10th dropped, OVF=1. Write STATUS data_in[3]=1 -> OVF=0.
//  4. Two queued bytes, DIV=3 -> second start bit immediately follows first stop bit
//     (frames 30 cycles apart, no idle cycle).
//  5. CTRL.irq_en=1; send one byte -> irq=0 during frame, irq=1 one cycle after STOP ends.
//     Write DIV=1 -> reads back 2.
//  6. Assert rst mid-DATA -> txd=1 immediately, FIFO empty.
//     After release, read/write outside the window -> rd_hit_q=0, rd_data=0, no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, TX state encoding and the DIV clamp helper.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A divisor below 2 cannot be counted by the baud counter, so it saturates at 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < 16'd2) ? 16'd2 : value;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count = wr_ptr_r - rd_ptr_r;
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array; no reset needed since contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window on the CPU data
// bus, TX FIFO, baud counter and frame serialiser.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] rd_data,
    output logic        rd_hit_q,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        hit_s;
    logic [1:0]  sel_s;
    logic        push_s;
    logic        pop_s;
    logic        ovf_clr_s;
    logic        div_wr_s;
    logic        ctrl_wr_s;
    logic [15:0] div_wr_val_s;
    logic [31:0] rd_mux_s;
    logic [3:0]  count4_s;
    logic        busy_s;

    logic [7:0]  fifo_dout_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [AW:0] fifo_count_s;

    logic [15:0] div_r;
    logic        irq_en_r;
    logic        ovf_r;
    logic [31:0] rd_data_r;
    logic        rd_hit_r;
    logic        irq_r;

    tx_state_e   state_r, state_n;
    logic [15:0] bcnt_r, bcnt_n;
    logic [15:0] div_q_r, div_q_n;
    logic [7:0]  shreg_r, shreg_n;
    logic [2:0]  idx_r, idx_n;
    logic        txd_r, txd_n;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (data_in[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign hit_s     = (data_addr[31:4] == BASE_ADDR[31:4]);
    assign sel_s     = data_addr[3:2];
    assign push_s    = hit_s & (sel_s == REG_TXDATA) & data_write[0];
    assign ovf_clr_s = hit_s & (sel_s == REG_STATUS) & data_write[0] & data_in[ST_OVF];
    assign div_wr_s  = hit_s & (sel_s == REG_DIV) & (|data_write[1:0]);
    assign ctrl_wr_s = hit_s & (sel_s == REG_CTRL) & data_write[0];
    assign busy_s    = (state_r != TX_IDLE);
    assign count4_s  = 4'(fifo_count_s);

    assign div_wr_val_s = clamp_div({data_write[1] ? data_in[15:8] : div_r[15:8],
                                     data_write[0] ? data_in[7:0]  : div_r[7:0]});

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = 32'd0;
        case (sel_s)
            REG_TXDATA: rd_mux_s = 32'd0;
            REG_STATUS: rd_mux_s = {24'd0, count4_s, ovf_r, busy_s, fifo_empty_s, fifo_full_s};
            REG_DIV:    rd_mux_s = {16'd0, div_r};
            REG_CTRL:   rd_mux_s = {31'd0, irq_en_r};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Control/status registers; OVF is sticky until software clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r    <= DEFAULT_DIV;
            irq_en_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (div_wr_s) begin
                div_r <= div_wr_val_s;
            end
            if (ctrl_wr_s) begin
                irq_en_r <= data_in[0];
            end
            if (push_s & fifo_full_s & ~pop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Bus read response and interrupt, both one cycle behind their source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= 32'd0;
            rd_hit_r  <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            rd_data_r <= (data_read & hit_s) ? rd_mux_s : 32'd0;
            rd_hit_r  <= data_read & hit_s;
            irq_r     <= irq_en_r & fifo_empty_s & ~busy_s;
        end
    end

    // TX next-state logic; a frame start (from IDLE or back-to-back from STOP) pops and latches DIV.
    always_comb begin
        state_n = state_r;
        bcnt_n  = bcnt_r;
        div_q_n = div_q_r;
        shreg_n = shreg_r;
        idx_n   = idx_r;
        txd_n   = txd_r;
        pop_s   = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shreg_n = fifo_dout_s;
                    div_q_n = div_r;
                    bcnt_n  = div_r - 16'd1;
                    state_n = TX_START;
                    txd_n   = 1'b0;
                end else begin
                    txd_n   = 1'b1;
                end
            end
            TX_START: begin
                if (bcnt_r == 16'd0) begin
                    state_n = TX_DATA;
                    bcnt_n  = div_q_r - 16'd1;
                    idx_n   = 3'd0;
                    txd_n   = shreg_r[0];
                end else begin
                    bcnt_n  = bcnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (bcnt_r == 16'd0) begin
                    bcnt_n = div_q_r - 16'd1;
                    idx_n  = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_n = TX_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        shreg_n = {1'b0, shreg_r[7:1]};
                        txd_n   = shreg_r[1];
                    end
                end else begin
                    bcnt_n = bcnt_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (bcnt_r == 16'd0) begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shreg_n = fifo_dout_s;
                        div_q_n = div_r;
                        bcnt_n  = div_r - 16'd1;
                        state_n = TX_START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = TX_IDLE;
                        txd_n   = 1'b1;
                    end
                end else begin
                    bcnt_n = bcnt_r - 16'd1;
                end
            end
            default: begin
                state_n = TX_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    // TX state register; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= TX_IDLE;
            bcnt_r  <= 16'd0;
            div_q_r <= DEFAULT_DIV;
            shreg_r <= 8'd0;
            idx_r   <= 3'd0;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_n;
            bcnt_r  <= bcnt_n;
            div_q_r <= div_q_n;
            shreg_r <= shreg_n;
            idx_r   <= idx_n;
            txd_r   <= txd_n;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_hit_q = rd_hit_r;
    assign txd      = txd_r;
    assign irq      = irq_r;

endmodule
